// File: rtl/hazard_stall.sv
// Pipeline interlock: load-use and MD-unit stalls, taken-branch flush,
// and the busy sequencer for the multi-cycle multiply/divide unit.
module hazard_stall #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_md_use,
  input  logic [4:0] ex_wr_reg,
  input  logic       ex_mem_read,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  input  logic       ex_branch_taken,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  md_state_t  state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       load_use;
  logic       md_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Loading N-1 and leaving at cnt==0 keeps BUSY for exactly N cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (ex_md_start) begin
          cnt_nx   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - 6'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_use = ex_mem_read && (ex_wr_reg != '0) &&
               ((id_use_rs && (id_rs == ex_wr_reg)) ||
                (id_use_rt && (id_rt == ex_wr_reg)));
    md_hold  = id_md_use && (ex_md_start || (state != IDLE));
    md_busy  = (state != IDLE);
    md_done  = (state == DONE);

    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    // A taken branch squashes the stalled instruction anyway, so it wins.
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || md_hold) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall; outputs packed as
// {pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done}.
module tb_hazard_stall;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr_reg;
  logic       id_use_rs, id_use_rt, id_md_use;
  logic       ex_mem_read, ex_md_start, ex_md_is_div, ex_branch_taken;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  hazard_stall #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_use(id_md_use), .ex_wr_reg(ex_wr_reg), .ex_mem_read(ex_mem_read),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done};

  localparam logic [5:0] ZERO     = 6'b000000;
  localparam logic [5:0] STALL    = 6'b110100;
  localparam logic [5:0] STALL_BZ = 6'b110110;
  localparam logic [5:0] STALL_DN = 6'b110111;
  localparam logic [5:0] BRANCH   = 6'b001100;
  localparam logic [5:0] BUSYONLY = 6'b000010;
  localparam logic [5:0] DONEONLY = 6'b000011;

  task automatic chk(input string name, input logic [5:0] exp);
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", name, outs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    id_rs = '0; id_rt = '0; ex_wr_reg = '0;
    id_use_rs = 0; id_use_rt = 0; id_md_use = 0;
    ex_mem_read = 0; ex_md_start = 0; ex_md_is_div = 0; ex_branch_taken = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("reset_held", ZERO);
    tick();
    rst = 1'b0;
    chk("reset_release", ZERO);

    // Load-use
    tick();
    ex_mem_read = 1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    chk("load_use_rs", STALL);
    tick();
    ex_mem_read = 0;
    chk("load_use_bubble_release", ZERO);
    ex_mem_read = 1; ex_wr_reg = 5'd0; id_rs = 5'd0;
    chk("load_use_r0", ZERO);
    ex_wr_reg = 5'd8; id_rs = 5'd8; id_use_rs = 0;
    chk("load_use_no_rs", ZERO);
    id_rt = 5'd8; id_use_rt = 1;
    chk("load_use_rt", STALL);
    id_rt = 5'd9;
    chk("load_use_rt_mismatch", ZERO);

    // Branch priority
    id_rt = 5'd8; ex_branch_taken = 1;
    chk("branch_over_load_use", BRANCH);
    idle_inputs();
    ex_branch_taken = 1;
    chk("branch_alone", BRANCH);
    idle_inputs();

    // Multiply with dependent mflo in ID
    tick();
    ex_md_start = 1; ex_md_is_div = 0; id_md_use = 1;
    chk("mul_start_hold", STALL);
    tick();
    ex_md_start = 0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_busy_c%0d", k), STALL_BZ);
      tick();
    end
    chk("mul_done_c5", STALL_DN);
    tick();
    chk("mul_release_c6", ZERO);
    id_md_use = 0;

    // Ignored start during BUSY; also combined load-use + md_hold
    tick();
    ex_md_start = 1; ex_md_is_div = 0;
    chk("ign_start_c0", ZERO);
    tick();
    ex_md_start = 0;
    chk("ign_busy_c1", BUSYONLY);
    tick();
    ex_md_start = 1; ex_md_is_div = 1;
    chk("ign_pulse_c2", BUSYONLY);
    ex_md_start = 0; ex_md_is_div = 0;
    id_md_use = 1; ex_mem_read = 1; ex_wr_reg = 5'd3; id_rs = 5'd3; id_use_rs = 1;
    chk("combined_stall_c2", STALL_BZ);
    idle_inputs();
    tick();
    chk("ign_busy_c3", BUSYONLY);
    tick();
    chk("ign_busy_c4", BUSYONLY);
    tick();
    chk("ign_done_c5", DONEONLY);
    tick();
    chk("ign_idle_c6", ZERO);

    // Back-to-back divides
    tick();
    ex_md_start = 1; ex_md_is_div = 1; id_md_use = 1;
    chk("div_start_hold", STALL);
    tick();
    ex_md_start = 0; ex_md_is_div = 0;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("div_busy_c%0d", k), STALL_BZ);
      tick();
    end
    chk("div_done_c33", STALL_DN);
    tick();
    id_md_use = 0; ex_md_start = 1; ex_md_is_div = 1;
    chk("div2_issue_c34", ZERO);
    tick();
    idle_inputs();
    // Second divide: cnt = 32 - k in cycle k, so cnt = 10 in cycle 22
    for (int k = 1; k <= 21; k++) begin
      chk($sformatf("div2_busy_c%0d", k), BUSYONLY);
      tick();
    end
    chk("div2_busy_c22", BUSYONLY);
    rst = 1'b1;
    chk("reset_mid_busy", ZERO);
    tick();
    rst = 1'b0;
    chk("reset_mid_release", ZERO);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("no_done_after_abort_%0d", k), ZERO);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
